// File: rtl/maze_game_pkg.sv
// Shared definitions for the maze game sequencer: FSM encodings, move
// directions, PS/2 prefix bytes and the per-player key map.
package maze_game_pkg;

  // FSM state encodings
  localparam logic [3:0] ST_START_SCREEN = 4'd0;
  localparam logic [3:0] ST_WAIT_FOR_SW  = 4'd1;
  localparam logic [3:0] ST_CLEAR_SCREEN = 4'd2;
  localparam logic [3:0] ST_DRAW_MAZE    = 4'd3;
  localparam logic [3:0] ST_DRAW_SPECIAL = 4'd4;
  localparam logic [3:0] ST_IDLE         = 4'd5;
  localparam logic [3:0] ST_ERASE_OLD    = 4'd6;
  localparam logic [3:0] ST_CHECK_MOVE   = 4'd7;
  localparam logic [3:0] ST_COMMIT       = 4'd8;
  localparam logic [3:0] ST_DRAW_NEW     = 4'd9;

  // Move directions; also the column index into KEY_CODE
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // PS/2 set-2 prefix bytes
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int MAX_PLAYERS = 4;

  // Whether a player's keys carry the E0 prefix
  localparam logic KEY_EXT [MAX_PLAYERS] = '{1'b0, 1'b1, 1'b0, 1'b0};

  // Scan codes per player, ordered up, down, left, right
  localparam logic [7:0] KEY_CODE [MAX_PLAYERS][4] = '{
    '{8'h1D, 8'h1B, 8'h1C, 8'h23},   // W S A D
    '{8'h75, 8'h72, 8'h6B, 8'h74},   // arrow keys (extended)
    '{8'h43, 8'h42, 8'h3B, 8'h4B},   // I K J L
    '{8'h75, 8'h73, 8'h6B, 8'h74}    // keypad 8 5 4 6
  };

  typedef struct packed {
    logic       hit;
    logic [1:0] player;
    logic [1:0] dir;
  } key_hit_t;

  // Map an (extended flag, code) pair to a player and direction
  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
    key_hit_t r;
    r = '0;
    for (int p = 0; p < MAX_PLAYERS; p++) begin
      for (int d = 0; d < 4; d++) begin
        if (!r.hit && (KEY_EXT[p] == ext) && (KEY_CODE[p][d] == code)) begin
          r.hit    = 1'b1;
          r.player = 2'(p);
          r.dir    = 2'(d);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/maze_game_control_ps2_move_decoder.sv
// Turns the PS/2 byte stream into one pending move (with direction) per
// player. Prefix flags track E0/F0; the latest make code for a player wins.
module ps2_move_decoder
  import maze_game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        byte_en,
  input  logic [7:0]                  byte_data,
  input  logic                        clear_pending,
  input  logic                        clear_prefix,
  input  logic                        clear_one_en,
  input  logic [PW-1:0]               clear_one_idx,
  output logic [NUM_PLAYERS-1:0]      pending,
  output logic [NUM_PLAYERS-1:0][1:0] dir
);

  logic                        ext_q, ext_d;
  logic                        brk_q, brk_d;
  logic [NUM_PLAYERS-1:0]      pending_q, pending_d;
  logic [NUM_PLAYERS-1:0][1:0] dir_q, dir_d;

  logic                        is_ext;
  logic                        is_brk;
  logic                        make_valid;
  key_hit_t                    hit;
  logic [NUM_PLAYERS-1:0]      set_vec;
  logic [NUM_PLAYERS-1:0]      clr_vec;

  // Classify the incoming byte and look it up with the current ext flag
  always_comb begin
    is_ext     = (byte_data == PS2_EXT);
    is_brk     = (byte_data == PS2_BRK);
    hit        = key_lookup(ext_q, byte_data);
    make_valid = byte_en && !is_ext && !is_brk && !brk_q && hit.hit;
  end

  // Per-player set/clear strobes; players beyond NUM_PLAYERS have no bit
  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      localparam logic [1:0]    PID  = 2'(gi);
      localparam logic [PW-1:0] PSEL = PW'(gi);
      assign set_vec[gi] = make_valid && (hit.player == PID);
      assign clr_vec[gi] = clear_one_en && (clear_one_idx == PSEL);
    end
  endgenerate

  // Next-state: a new make beats the arbiter's clear, flushes beat everything
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    pending_d = (pending_q & ~clr_vec) | set_vec;
    dir_d     = dir_q;
    if (byte_en) begin
      if (is_ext) begin
        ext_d = 1'b1;
      end else if (is_brk) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (set_vec[i]) begin
        dir_d[i] = hit.dir;
      end
    end
    if (clear_pending) begin
      pending_d = '0;
    end
    if (clear_prefix) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  // Decoder registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      pending_q <= '0;
      dir_q     <= '0;
    end else begin
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
    end
  end

  assign pending = pending_q;
  assign dir     = dir_q;

endmodule

// File: rtl/maze_game_control.sv
// Game sequencer: walks the screen/maze/special setup, then serves queued
// player moves round-robin through erase, legality check, commit and draw.
module maze_game_control
  import maze_game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_LEVELS  = 3,
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_LEVELS-1:0] level_sw,
  input  logic                  received_data_en,
  input  logic [7:0]            received_data,
  input  logic                  doneScreen,
  input  logic                  doneMaze,
  input  logic                  doneSpecial,
  input  logic                  doneErase,
  input  logic                  doneCheckLegal,
  input  logic                  doneDraw,
  input  logic                  isLegal,
  output logic                  drawStart,
  output logic                  drawClear,
  output logic                  drawMaze,
  output logic                  drawSpecial,
  output logic                  eraseBox,
  output logic                  checkMove,
  output logic                  drawBox,
  output logic                  commitMove,
  output logic                  doneChangePosition,
  output logic [PW-1:0]         activePlayer,
  output logic [1:0]            moveDir,
  output logic [LW-1:0]         level
);

  logic [3:0]    state_q, state_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [PW-1:0] active_q, active_d;
  logic [1:0]    dir_q, dir_d;
  logic [LW-1:0] level_q, level_d;
  logic          done_change_q, done_change_d;

  logic [NUM_PLAYERS-1:0]      pending;
  logic [NUM_PLAYERS-1:0][1:0] pend_dir;
  logic                        clear_pending;
  logic                        clear_prefix;
  logic                        clear_one_en;

  logic          grant_valid;
  logic [PW-1:0] grant_idx;
  logic [1:0]    grant_dir;
  logic [PW-1:0] rr_after;
  logic [LW-1:0] level_hi;
  logic          abort;

  ps2_move_decoder #(
    .NUM_PLAYERS(NUM_PLAYERS)
  ) u_decoder (
    .clock        (clock),
    .reset        (reset),
    .byte_en      (received_data_en),
    .byte_data    (received_data),
    .clear_pending(clear_pending),
    .clear_prefix (clear_prefix),
    .clear_one_en (clear_one_en),
    .clear_one_idx(grant_idx),
    .pending      (pending),
    .dir          (pend_dir)
  );

  // Round-robin pick: first pending at or after rr, else first from 0
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_dir   = DIR_UP;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!grant_valid && (i >= int'(rr_q)) && pending[i]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(i);
        grant_dir   = pend_dir[i];
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!grant_valid && pending[i]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(i);
        grant_dir   = pend_dir[i];
      end
    end
    rr_after = '0;
    for (int i = 0; i < NUM_PLAYERS - 1; i++) begin
      if (grant_idx == PW'(i)) begin
        rr_after = PW'(i + 1);
      end
    end
  end

  // Highest set level switch selects the level
  always_comb begin
    level_hi = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (level_sw[i]) begin
        level_hi = LW'(i);
      end
    end
  end

  // Main sequencer; an all-zero switch bank aborts any in-game state
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    active_d      = active_q;
    dir_d         = dir_q;
    level_d       = level_q;
    done_change_d = 1'b0;
    clear_pending = 1'b0;
    clear_prefix  = 1'b0;
    clear_one_en  = 1'b0;
    abort = (state_q != ST_START_SCREEN) && (state_q != ST_WAIT_FOR_SW) &&
            (level_sw == '0);

    if (abort) begin
      state_d       = ST_START_SCREEN;
      clear_pending = 1'b1;
      clear_prefix  = 1'b1;
    end else begin
      case (state_q)
        ST_START_SCREEN: if (doneScreen)  state_d = ST_WAIT_FOR_SW;
        ST_WAIT_FOR_SW: begin
          if (level_sw != '0) begin
            state_d = ST_CLEAR_SCREEN;
            level_d = level_hi;
          end
        end
        ST_CLEAR_SCREEN: if (doneScreen)  state_d = ST_DRAW_MAZE;
        ST_DRAW_MAZE:    if (doneMaze)    state_d = ST_DRAW_SPECIAL;
        ST_DRAW_SPECIAL: begin
          if (doneSpecial) begin
            state_d       = ST_IDLE;
            clear_pending = 1'b1;
          end
        end
        ST_IDLE: begin
          if (grant_valid) begin
            state_d      = ST_ERASE_OLD;
            active_d     = grant_idx;
            dir_d        = grant_dir;
            rr_d         = rr_after;
            clear_one_en = 1'b1;
          end
        end
        ST_ERASE_OLD:    if (doneErase)   state_d = ST_CHECK_MOVE;
        ST_CHECK_MOVE: begin
          if (doneCheckLegal) begin
            state_d = isLegal ? ST_COMMIT : ST_DRAW_NEW;
          end
        end
        ST_COMMIT:       state_d = ST_DRAW_NEW;
        ST_DRAW_NEW: begin
          if (doneDraw) begin
            state_d       = ST_IDLE;
            done_change_d = 1'b1;
          end
        end
        default:         state_d = ST_START_SCREEN;
      endcase
    end
  end

  // Sequencer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_START_SCREEN;
      rr_q          <= '0;
      active_q      <= '0;
      dir_q         <= DIR_UP;
      level_q       <= '0;
      done_change_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      active_q      <= active_d;
      dir_q         <= dir_d;
      level_q       <= level_d;
      done_change_q <= done_change_d;
    end
  end

  // Moore engine requests decoded from the registered state
  always_comb begin
    drawStart   = (state_q == ST_START_SCREEN);
    drawClear   = (state_q == ST_CLEAR_SCREEN);
    drawMaze    = (state_q == ST_DRAW_MAZE);
    drawSpecial = (state_q == ST_DRAW_SPECIAL);
    eraseBox    = (state_q == ST_ERASE_OLD);
    checkMove   = (state_q == ST_CHECK_MOVE);
    drawBox     = (state_q == ST_DRAW_NEW);
    commitMove  = (state_q == ST_COMMIT);
  end

  assign doneChangePosition = done_change_q;
  assign activePlayer       = active_q;
  assign moveDir            = dir_q;
  assign level              = level_q;

endmodule

// File: tb/tb_maze_game_control.sv
// Directed bench for maze_game_control (2 players, 3 level switches).
module tb_maze_game_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] level_sw = 3'b000;
  logic       received_data_en = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       doneScreen = 1'b0, doneMaze = 1'b0, doneSpecial = 1'b0;
  logic       doneErase = 1'b0, doneCheckLegal = 1'b0, doneDraw = 1'b0;
  logic       isLegal = 1'b0;
  logic       drawStart, drawClear, drawMaze, drawSpecial, eraseBox, checkMove, drawBox;
  logic       commitMove, doneChangePosition;
  logic [0:0] activePlayer;
  logic [1:0] moveDir;
  logic [1:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  // Output vector: start clear maze special erase check draw commit donechg
  logic [8:0] outs;
  assign outs = {drawStart, drawClear, drawMaze, drawSpecial, eraseBox,
                 checkMove, drawBox, commitMove, doneChangePosition};

  localparam logic [8:0] O_NONE   = 9'h000;
  localparam logic [8:0] O_START  = 9'h100;
  localparam logic [8:0] O_CLEAR  = 9'h080;
  localparam logic [8:0] O_MAZE   = 9'h040;
  localparam logic [8:0] O_SPEC   = 9'h020;
  localparam logic [8:0] O_ERASE  = 9'h010;
  localparam logic [8:0] O_CHECK  = 9'h008;
  localparam logic [8:0] O_DRAW   = 9'h004;
  localparam logic [8:0] O_COMMIT = 9'h002;
  localparam logic [8:0] O_DCP    = 9'h001;

  localparam logic [5:0] D_SCREEN  = 6'b100000;
  localparam logic [5:0] D_MAZE    = 6'b010000;
  localparam logic [5:0] D_SPECIAL = 6'b001000;
  localparam logic [5:0] D_ERASE   = 6'b000100;
  localparam logic [5:0] D_CHECK   = 6'b000010;
  localparam logic [5:0] D_DRAW    = 6'b000001;

  maze_game_control dut (
    .clock             (clock),
    .reset             (reset),
    .level_sw          (level_sw),
    .received_data_en  (received_data_en),
    .received_data     (received_data),
    .doneScreen        (doneScreen),
    .doneMaze          (doneMaze),
    .doneSpecial       (doneSpecial),
    .doneErase         (doneErase),
    .doneCheckLegal    (doneCheckLegal),
    .doneDraw          (doneDraw),
    .isLegal           (isLegal),
    .drawStart         (drawStart),
    .drawClear         (drawClear),
    .drawMaze          (drawMaze),
    .drawSpecial       (drawSpecial),
    .eraseBox          (eraseBox),
    .checkMove         (checkMove),
    .drawBox           (drawBox),
    .commitMove        (commitMove),
    .doneChangePosition(doneChangePosition),
    .activePlayer      (activePlayer),
    .moveDir           (moveDir),
    .level             (level)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    received_data    = b;
    received_data_en = 1'b1;
    tick();
    received_data_en = 1'b0;
  endtask

  task automatic pulse(input logic [5:0] m);
    {doneScreen, doneMaze, doneSpecial, doneErase, doneCheckLegal, doneDraw} = m;
    tick();
    {doneScreen, doneMaze, doneSpecial, doneErase, doneCheckLegal, doneDraw} = 6'b0;
  endtask

  initial begin
    // Reset
    tick(); tick();
    reset = 1'b0;
    check("reset_outs", 32'(outs), 32'(O_START));
    check("reset_player", 32'(activePlayer), 0);
    check("reset_dir", 32'(moveDir), 0);
    check("reset_level", 32'(level), 0);

    // Setup sequence
    pulse(D_SCREEN);
    check("wait_sw_outs", 32'(outs), 32'(O_NONE));
    tick();
    check("wait_sw_hold", 32'(outs), 32'(O_NONE));
    level_sw = 3'b010;
    tick();
    check("clear_outs", 32'(outs), 32'(O_CLEAR));
    check("level_latched", 32'(level), 1);
    pulse(D_MAZE);
    check("stale_done_clear", 32'(outs), 32'(O_CLEAR));
    pulse(D_SCREEN);
    check("maze_outs", 32'(outs), 32'(O_MAZE));
    pulse(D_MAZE);
    check("special_outs", 32'(outs), 32'(O_SPEC));
    send(8'h1D);
    pulse(D_SPECIAL);
    check("idle_outs", 32'(outs), 32'(O_NONE));
    tick();
    check("prekey_discarded", 32'(outs), 32'(O_NONE));
    pulse(D_ERASE);
    check("stale_done_idle", 32'(outs), 32'(O_NONE));
    level_sw = 3'b001;

    // P0 up, legal
    send(8'h1D);
    check("key_to_idle", 32'(outs), 32'(O_NONE));
    tick();
    check("m1_erase", 32'(outs), 32'(O_ERASE));
    check("m1_player", 32'(activePlayer), 0);
    check("m1_dir", 32'(moveDir), 0);
    check("level_unchanged", 32'(level), 1);
    pulse(D_ERASE);
    check("m1_check", 32'(outs), 32'(O_CHECK));
    isLegal = 1'b1;
    pulse(D_CHECK);
    isLegal = 1'b0;
    check("m1_commit", 32'(outs), 32'(O_COMMIT));
    tick();
    check("m1_draw", 32'(outs), 32'(O_DRAW));
    tick();
    check("m1_draw_hold", 32'(outs), 32'(O_DRAW));
    pulse(D_DRAW);
    check("m1_donechg", 32'(outs), 32'(O_DCP));
    tick();
    check("m1_donechg_pulse", 32'(outs), 32'(O_NONE));

    // P1 left (extended), illegal
    send(8'hE0);
    send(8'h6B);
    tick();
    check("m2_erase", 32'(outs), 32'(O_ERASE));
    check("m2_player", 32'(activePlayer), 1);
    check("m2_dir", 32'(moveDir), 2);
    pulse(D_ERASE);
    pulse(D_CHECK);
    check("m2_no_commit", 32'(outs), 32'(O_DRAW));
    pulse(D_DRAW);
    check("m2_donechg", 32'(outs), 32'(O_DCP));
    tick();
    check("m2_idle", 32'(outs), 32'(O_NONE));

    // Break code queues nothing
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    tick();
    check("break_ignored", 32'(outs), 32'(O_NONE));
    tick();
    check("break_ignored2", 32'(outs), 32'(O_NONE));

    // Round-robin: serve P0 so rr=1, queue P0 and P1 during its DRAW_NEW
    send(8'h1D);
    tick();
    check("rr_pre_player", 32'(activePlayer), 0);
    pulse(D_ERASE);
    isLegal = 1'b1;
    pulse(D_CHECK);
    isLegal = 1'b0;
    tick();
    check("rr_pre_draw", 32'(outs), 32'(O_DRAW));
    send(8'h23);
    send(8'hE0);
    send(8'h74);
    pulse(D_DRAW);
    check("rr_pre_donechg", 32'(outs), 32'(O_DCP));
    tick();
    check("rr_first_erase", 32'(outs), 32'(O_ERASE));
    check("rr_first_player", 32'(activePlayer), 1);
    check("rr_first_dir", 32'(moveDir), 3);
    pulse(D_ERASE);
    pulse(D_CHECK);
    pulse(D_DRAW);
    tick();
    check("rr_second_erase", 32'(outs), 32'(O_ERASE));
    check("rr_second_player", 32'(activePlayer), 0);
    check("rr_second_dir", 32'(moveDir), 3);
    pulse(D_ERASE);
    pulse(D_CHECK);
    pulse(D_DRAW);
    tick();
    check("rr_drained", 32'(outs), 32'(O_NONE));
    send(8'h1D);
    tick();
    check("requeue_player", 32'(activePlayer), 0);
    check("requeue_dir", 32'(moveDir), 0);

    // Two makes for P0 coalesce into one move with the latest direction
    pulse(D_ERASE);
    send(8'h1D);
    send(8'h1B);
    pulse(D_CHECK);
    pulse(D_DRAW);
    tick();
    check("coalesce_erase", 32'(outs), 32'(O_ERASE));
    check("coalesce_dir", 32'(moveDir), 1);
    pulse(D_ERASE);
    pulse(D_CHECK);
    pulse(D_DRAW);
    tick();
    check("coalesce_single", 32'(outs), 32'(O_NONE));

    // Make for P0 in the very cycle it is granted keeps it pending
    send(8'h1D);
    send(8'h1C);
    check("same_cycle_erase", 32'(outs), 32'(O_ERASE));
    check("same_cycle_dir", 32'(moveDir), 0);
    pulse(D_ERASE);
    pulse(D_CHECK);
    pulse(D_DRAW);
    tick();
    check("same_cycle_reserve", 32'(outs), 32'(O_ERASE));
    check("same_cycle_newdir", 32'(moveDir), 2);

    // Abort in CHECK_MOVE with a simultaneous legal done
    pulse(D_ERASE);
    check("abort_pre_check", 32'(outs), 32'(O_CHECK));
    send(8'h1D);
    send(8'hE0);
    level_sw       = 3'b000;
    isLegal        = 1'b1;
    doneCheckLegal = 1'b1;
    tick();
    doneCheckLegal = 1'b0;
    isLegal        = 1'b0;
    check("abort_start", 32'(outs), 32'(O_START));
    tick();
    check("abort_no_commit", 32'(outs), 32'(O_START));

    // Replay with highest-set level; stale E0 prefix must be gone
    pulse(D_SCREEN);
    level_sw = 3'b101;
    tick();
    check("replay_level", 32'(level), 2);
    pulse(D_SCREEN);
    pulse(D_MAZE);
    pulse(D_SPECIAL);
    check("replay_idle", 32'(outs), 32'(O_NONE));
    send(8'h75);
    tick();
    check("prefix_cleared", 32'(outs), 32'(O_NONE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_game_control.md
Name: maze_game_control

Overview:
- Parametrised top-level game sequencer for the maze game; replaces the single-player position controller.
- Decodes PS/2 set-2 scan-code bytes, including E0 extended and F0 break prefixes, into per-player move requests.
- Queues one pending move per player and serves players round-robin.
- Drives the screen, maze, special-box, erase, legality-check and draw engines through done-handshakes, for 1..4 players and a switch-selected level.

Parameters:
- NUM_PLAYERS, 2, number of player cursors (1..4); PW = max(1, clog2(NUM_PLAYERS)).
- NUM_LEVELS, 3, number of level-select switches; LW = max(1, clog2(NUM_LEVELS)).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- level_sw  in  NUM_LEVELS  level-select switches; all-zero = quit to start screen
- received_data_en  in  1  one-cycle strobe, one per received PS/2 byte
- received_data  in  8  PS/2 byte
- doneScreen, doneMaze, doneSpecial, doneErase, doneCheckLegal, doneDraw  in  1 each  engine completion pulses
- isLegal  in  1  legality result, valid in the cycle doneCheckLegal=1
- drawStart, drawClear, drawMaze, drawSpecial, eraseBox, checkMove, drawBox  out  1 each  engine requests
- commitMove  out  1  one-cycle pulse: update position of activePlayer
- doneChangePosition  out  1  one-cycle pulse when a move service completes
- activePlayer  out  PW  player being served
- moveDir  out  2  served direction: 0 up, 1 down, 2 left, 3 right
- level  out  LW  latched level index

Behaviour:
- Reset (synchronous, active-high): state START_SCREEN, pending=0, prefix flags=0, rr pointer=0, activePlayer=0, moveDir=0, level=0.
- After reset: drawStart=1; every other output 0.
- Engine requests are Moore outputs decoded from the registered state. commitMove and doneChangePosition are single-cycle pulses.
- Byte decoder (runs in every state):
  - E0 sets ext; F0 sets brk.
  - Any other byte is a code: it is looked up with ext, then ext and brk are cleared.
  - A make code (brk=0) matching player p (p < NUM_PLAYERS) sets pending[p] and dir[p]. The latest make overwrites the earlier one.
  - Break codes and unmapped codes are ignored.
- Key map, set-2 codes:
  - P0, non-extended: W 1D, S 1B, A 1C, D 23.
  - P1, extended: up 75, down 72, left 6B, right 74.
  - P2, non-extended: I 43, K 42, J 3B, L 4B.
  - P3, non-extended keypad: 8 75, 5 73, 4 6B, 6 74.
- FSM states and transitions:
  - START_SCREEN: wait for doneScreen -> WAIT_FOR_SW.
  - WAIT_FOR_SW: when any level_sw is set -> CLEAR_SCREEN; level is latched to the highest set index.
  - CLEAR_SCREEN: drawClear; doneScreen -> DRAW_MAZE.
  - DRAW_MAZE: drawMaze; doneMaze -> DRAW_SPECIAL.
  - DRAW_SPECIAL: drawSpecial; doneSpecial -> IDLE, and pending is cleared so keys pressed before play are discarded.
  - IDLE: if pending != 0, pick the first pending player at or after the rr pointer (wrapping), latch activePlayer and moveDir, clear that pending bit, set rr = winner+1 mod NUM_PLAYERS, and go to ERASE_OLD.
  - ERASE_OLD: eraseBox; doneErase -> CHECK_MOVE.
  - CHECK_MOVE: checkMove; on doneCheckLegal, go to COMMIT if isLegal=1, else to DRAW_NEW.
  - COMMIT: commitMove=1 for one cycle -> DRAW_NEW.
  - DRAW_NEW: drawBox; doneDraw -> IDLE with doneChangePosition=1 in that cycle.
- Abort: from any state after WAIT_FOR_SW, level_sw == 0 forces START_SCREEN next cycle. Pending and prefixes are cleared; all done inputs in that cycle are ignored.
- level_sw changes to another nonzero value mid-game: ignored until the game returns to the start screen.
- Simultaneous events:
  - A make code for the player being selected in the same IDLE cycle: the bit stays set and dir is updated; that player is not served again until the others have had their turn.
  - Done pulses arriving in a state that does not expect them are ignored.
- Worst-case latency from a pending key in IDLE to eraseBox=1: one cycle.

Decomposition:
- Package maze_game_pkg holds:
  - state encodings;
  - direction codes;
  - PS/2 constants (E0, F0);
  - the per-player key-code table;
  - function key_lookup(ext, code) -> {hit, player, dir}.
- One sub-module, ps2_move_decoder, holds the prefix flags, pending bits and dir registers, and exposes pending/dir plus a clear port. The FSM and round-robin arbiter stay in maze_game_control.

Test Plan:
- Reset, then doneScreen, then level_sw=3'b010 -> states CLEAR, MAZE, SPECIAL, IDLE via done pulses; level=1; drawClear/drawMaze/drawSpecial each asserted only in its own state.
- Bytes 1D with isLegal=1 -> activePlayer=0, moveDir=0; eraseBox, checkMove, a one-cycle commitMove, drawBox, then doneChangePosition one cycle after doneDraw.
- Bytes E0 6B with isLegal=0 -> activePlayer=1, moveDir=2; commitMove never asserts. Byte sequence E0 F0 6B queues nothing.
- During DRAW_NEW send 23 (P0) then E0 74 (P1), with rr=1 -> P1 (dir 3) is served first, then P0 (dir 3); next key 1D queues P0 again.
- Bytes 1D then 1B before IDLE service -> a single P0 move with moveDir=1.
- In CHECK_MOVE set level_sw=0 with a simultaneous doneCheckLegal -> START_SCREEN next cycle, no commitMove, pending=0, drawStart=1.
